alu_cmd_issuer: RTL

- Command front-end for the 16-bit registered ALU.
- Accepts tagged operation requests over a valid/ready handshake, drives the ALU's A/B/ALU_FUN inputs from registers, and waits out the ALU's one-clock result latency.
- Captures ALU_OUT, Carry_Flag and the four class flags into a response register returned over a second valid/ready handshake.
- Screens illegal opcodes and divide-by-zero before they reach the ALU.

---
 rtl/alu_cmd_issuer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command front-end for the 16-bit registered ALU.
// Takes one tagged request at a time and drives the ALU from registers.
// It waits out the ALU's one-clock result latency, then captures the result
// and class flags into a response register with its own valid/ready handshake.
// Illegal opcodes and divide-by-zero are screened at acceptance. Such requests
// reach the ALU as the no-op opcode and return a synthesised error response.
//
// Timing for a request accepted on edge E:
//   edge E   : operands, opcode and tag registered; state -> ISSUE
//   edge E+1 : ALU samples alu_a/alu_b/alu_fun; state -> WAIT
//   edge E+2 : result captured, rsp_valid rises; state -> RESP
// IDLE, ISSUE, WAIT and RESP each last at least one cycle, so one operation
// takes at least four cycles.
module alu_cmd_issuer #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // request handshake
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_fun,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    // ALU operand side
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [3:0]       alu_fun,
    // ALU result side
    input  logic [15:0]      alu_out,
    input  logic             alu_carry,
    input  logic             alu_arith,
    input  logic             alu_logic,
    input  logic             alu_cmp,
    input  logic             alu_shift,
    // response handshake
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic             rsp_carry,
    output logic [3:0]       rsp_class,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    // statistics
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0]  FUN_DIV       = 4'b0011;
    localparam logic [3:0]  FUN_NOP       = 4'b1111;
    localparam logic [15:0] DIV0_DATA     = 16'hFFFF;
    localparam logic [3:0]  DIV0_CLASS    = 4'b0001;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             r_state;
    logic [15:0]        r_alu_a;
    logic [15:0]        r_alu_b;
    logic [3:0]         r_alu_fun;
    logic               r_err;
    logic               r_div0;
    logic [TAG_W-1:0]   r_tag;
    logic               r_rsp_valid;
    logic [15:0]        r_rsp_data;
    logic               r_rsp_carry;
    logic [3:0]         r_rsp_class;
    logic               r_rsp_err;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [CNT_W-1:0]   r_op_count;

    // Request screening, evaluated on the accept cycle only.
    logic w_illegal;
    logic w_div0;
    logic w_accept;
    logic w_rsp_done;
    logic [3:0] w_alu_class;

    assign w_illegal   = (cmd_fun == FUN_NOP);
    assign w_div0      = (cmd_fun == FUN_DIV) && (cmd_b == 16'h0000);
    assign w_accept    = cmd_valid && (r_state == ST_IDLE);
    assign w_rsp_done  = r_rsp_valid && rsp_ready;
    assign w_alu_class = {alu_shift, alu_cmp, alu_logic, alu_arith};

    // Ready depends on state alone, so a request is never half-accepted.
    assign cmd_ready = (r_state == ST_IDLE);

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_fun   = r_alu_fun;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_class = r_rsp_class;
    assign rsp_err   = r_rsp_err;
    assign rsp_tag   = r_tag_out();
    assign op_count  = r_op_count;

    function automatic logic [TAG_W-1:0] r_tag_out();
        return r_rsp_tag;
    endfunction

    // Issuer state machine with every output registered.
    always_ff @(posedge clk) begin
        // NOTE: a synchronous reset clears every register here, including the
        // response payload. An operation in flight is simply dropped.
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_alu_a     <= 16'h0000;
            r_alu_b     <= 16'h0000;
            r_alu_fun   <= FUN_NOP;
            r_err       <= 1'b0;
            r_div0      <= 1'b0;
            r_tag       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_rsp_carry <= 1'b0;
            r_rsp_class <= 4'b0000;
            r_rsp_err   <= 1'b0;
            r_rsp_tag   <= '0;
            r_op_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every register updates
            // from the values present before the edge, whatever the statement order.
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_a <= cmd_a;
                        r_tag   <= cmd_tag;
                        if (w_div0) begin
                            r_alu_b   <= 16'h0000;
                            r_alu_fun <= FUN_NOP;
                            r_err     <= 1'b1;
                            r_div0    <= 1'b1;
                        end else if (w_illegal) begin
                            r_alu_b   <= cmd_b;
                            r_alu_fun <= FUN_NOP;
                            r_err     <= 1'b1;
                            r_div0    <= 1'b0;
                        end else begin
                            r_alu_b   <= cmd_b;
                            r_alu_fun <= cmd_fun;
                            r_err     <= 1'b0;
                            r_div0    <= 1'b0;
                        end
                        r_state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // The ALU registers its operands at the end of this cycle.
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (!r_err) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_carry <= alu_carry;
                        r_rsp_class <= w_alu_class;
                    end else if (r_div0) begin
                        r_rsp_data  <= DIV0_DATA;
                        r_rsp_carry <= 1'b0;
                        r_rsp_class <= DIV0_CLASS;
                    end else begin
                        r_rsp_data  <= 16'h0000;
                        r_rsp_carry <= 1'b0;
                        r_rsp_class <= 4'b0000;
                    end
                    r_rsp_err   <= r_err;
                    r_rsp_tag   <= r_tag;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end

                ST_RESP: begin
                    // Payload is held untouched until the consumer takes it.
                    if (w_rsp_done) begin
                        r_rsp_valid <= 1'b0;
                        if (r_op_count != CNT_MAX) begin
                            r_op_count <= r_op_count + 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
